// File: rtl/agc_scaler_pkg.sv
// agc_scaler_pkg: shared scaler constants and stage tap indices
package agc_scaler_pkg;
  localparam int SCALER_STAGES = 15;
  localparam int SCALER_SYNC   = 2;
  localparam int IDX_FS03 = 0;
  localparam int IDX_FS04 = 1;
  localparam int IDX_FS05 = 2;
  localparam int IDX_FS06 = 3;
  localparam int IDX_FS07 = 4;
  localparam int IDX_FS08 = 5;
  localparam int IDX_FS09 = 6;
  localparam int IDX_FS10 = 7;
  localparam int IDX_FS11 = 8;
  localparam int IDX_FS12 = 9;
  localparam int IDX_FS13 = 10;
  localparam int IDX_FS14 = 11;
  localparam int IDX_FS15 = 12;
  localparam int IDX_FS16 = 13;
  localparam int IDX_FS17 = 14;
endpackage

// File: rtl/agc_scaler_chain_if.sv
// agc_scaler_chain_if: four-phase snapshot-read handshake
interface agc_scaler_chain_if
  import agc_scaler_pkg::*;
#(
  parameter int W = SCALER_STAGES
);
  logic         rd_req;
  logic         rd_ack;
  logic [W-1:0] rd_data;
  logic         rd_lost;
  modport master(output rd_req, input rd_ack, rd_data, rd_lost);
  modport slave(input rd_req, output rd_ack, rd_data, rd_lost);
endinterface

// File: rtl/agc_scaler_chain_edge_sync.sv
// agc_edge_sync: FS02 synchronizer with registered falling-edge pulse
module agc_edge_sync
  import agc_scaler_pkg::*;
#(
  parameter int SYNC = SCALER_SYNC
) (
  input  logic clk,
  input  logic rst_,
  input  logic i_fs02,
  output logic o_fall
);
  logic [SYNC-1:0] r_sync;
  logic            r_fs02_d;
  logic            r_fall;
  logic            w_fs02_s;
  assign w_fs02_s = r_sync[SYNC-1];
  assign o_fall   = r_fall;
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_sync   <= '0;
      r_fs02_d <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC-2:0], i_fs02};
      r_fs02_d <= w_fs02_s;
      r_fall   <= r_fs02_d & ~w_fs02_s;
    end
  end
endmodule

// File: rtl/agc_scaler_chain.sv
// agc_scaler_chain: FS03..FS17 scaler counter with edge strobes and snapshot read
module agc_scaler_chain
  import agc_scaler_pkg::*;
#(
  parameter int STAGES = SCALER_STAGES,
  parameter int SYNC   = SCALER_SYNC
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              FS02,
  input  logic              hold,
  output logic [STAGES-1:0] FS,
  output logic [STAGES-1:0] FA,
  output logic [STAGES-1:0] FB,
  output logic              wrap,
  output logic              lost,
  agc_scaler_chain_if.slave rd
);
  logic [STAGES-1:0] r_cnt, r_fa, r_fb, w_next;
  logic              r_wrap, r_lost, w_fall, w_step, w_capture;
  agc_edge_sync #(.SYNC(SYNC)) u_sync (
    .clk    (clk),
    .rst_   (rst_),
    .i_fs02 (FS02),
    .o_fall (w_fall)
  );
  assign w_step    = w_fall & ~hold;
  assign w_capture = rd.rd_req & ~rd.rd_ack;
  assign w_next    = r_cnt + STAGES'(1);
  assign FS        = r_cnt;
  assign FA        = r_fa;
  assign FB        = r_fb;
  assign wrap      = r_wrap;
  assign lost      = r_lost;
  // capture samples the pre-edge count; a dropped edge on the capture edge keeps lost set
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_cnt      <= '0;
      r_fa       <= '0;
      r_fb       <= '0;
      r_wrap     <= 1'b0;
      r_lost     <= 1'b0;
      rd.rd_ack  <= 1'b0;
      rd.rd_data <= '0;
      rd.rd_lost <= 1'b0;
    end else begin
      r_cnt     <= w_step ? w_next : r_cnt;
      r_fa      <= w_step ? (w_next & ~r_cnt) : '0;
      r_fb      <= w_step ? (r_cnt & ~w_next) : '0;
      r_wrap    <= w_step & (&r_cnt);
      r_lost    <= (w_fall & hold) | (r_lost & ~w_capture);
      rd.rd_ack <= rd.rd_req;
      if (w_capture) begin
        rd.rd_data <= r_cnt;
        rd.rd_lost <= r_lost;
      end
    end
  end
endmodule

// File: doc/agc_scaler_chain.md
Name: agc_scaler_chain

Overview:
Synchronous implementation of the scaler stages downstream of the A1 first-stage divider, counting FS03 through FS17. Takes the FS02 level produced by A1 and counts its falling edges in a binary ripple-equivalent counter. Emits the FSnn stage levels and one-cycle rise/fall strobes (FnnA/FnnB equivalents) for timing consumers. Provides a four-phase snapshot-read handshake so a reader gets a coherent count.

Parameters:
STAGES, 15, number of scaler stages; bit 0 is FS03 and bit STAGES-1 is FS17.
SYNC, 2, flip-flop depth of the FS02 synchronizer (minimum 2).

Ports:
clk  in  1  single system clock; all state is updated on its rising edge
rst_  in  1  asynchronous, active-low reset
FS02  in  1  FS02 level from A1; asynchronous to clk
hold  in  1  scaler inhibit; while high, edges are not counted
FS  out  STAGES  stage levels; FS[i] is FS(i+3)
FA  out  STAGES  one-cycle strobe when FS[i] goes 0->1
FB  out  STAGES  one-cycle strobe when FS[i] goes 1->0
wrap  out  1  one-cycle strobe when the count rolls over from all-ones to 0
lost  out  1  sticky flag: at least one FS02 edge was dropped because hold was high
rd_req  in  1  snapshot request (level, four-phase)
rd_ack  out  1  snapshot acknowledge
rd_data  out  STAGES  captured count
rd_lost  out  1  value of lost at the moment of capture

Behaviour:
- Reset (rst_ low, asynchronous): the counter, FS, FA, FB, wrap, lost, rd_ack, rd_data, rd_lost and all synchronizer flops go to 0. The block leaves reset on the first clk edge after rst_ goes high.
- Synchronizer: FS02 passes through SYNC flops to give fs02_s, then one more flop to give fs02_d.
- Falling-edge detect: fall = fs02_d & ~fs02_s.
- Latency: an FS02 falling edge is first sampled at clk edge k. FS updates at edge k+SYNC+1.
- Count step: on fall & ~hold, the counter increments by 1 modulo 2^STAGES. FS equals the counter register with no extra delay.
- Strobes: FA, FB and wrap are registered and are high in exactly the same cycle FS shows the new value. They are 0 in every other cycle.
  - FA[i] = 1 when bit i goes 0->1.
  - FB[i] = 1 when bit i goes 1->0.
  - wrap = 1 when the count goes from all-ones to 0; in that cycle every FB bit is also 1.
- Hold: on fall & hold, the counter is unchanged, no strobes fire, and lost is set to 1. lost stays at 1 until it is cleared by a snapshot capture. Edges arriving while hold is high are not counted later.
- Read handshake, four-phase:
  - Capture: at the edge where rd_req=1 and rd_ack=0, rd_data takes the counter register value from before that edge and rd_lost takes lost. rd_ack goes to 1 at the same edge.
  - Hold-off: rd_ack stays at 1 while rd_req=1, and rd_data does not change.
  - Release: at the first edge with rd_req=0, rd_ack goes to 0.
  - Minimum cycle: a new capture needs rd_req to be low for at least one cycle after rd_ack has fallen.
- Simultaneous events:
  - Increment and capture on the same edge: the pre-increment value is captured, and the counter still increments.
  - Lost set and capture on the same edge: rd_lost captures the old value of lost, and lost ends up 1 (set wins over clear).
- Reset in mid-operation, including mid-handshake: everything clears immediately and asynchronously. The reader sees rd_ack=0 and must re-request.
- Widths: all arithmetic is STAGES bits. There is no carry-out except the wrap strobe.

Decomposition:
- Shared package agc_scaler_pkg holds:
  - the constants SCALER_STAGES=15 and SCALER_SYNC=2;
  - the stage-index localparams IDX_FS03..IDX_FS17 (for example, IDX_FS10=7), so consumers can pick out F10 and similar taps.
- One sub-module, agc_edge_sync: the SYNC-deep synchronizer plus the falling-edge detector. It is instantiated once and produces fall. The counter, strobes and handshake stay in the top module.

Test Plan:
1. Reset: hold rst_ low while FS02 toggles. Expect FS=0, FA=FB=0, wrap=0, lost=0, rd_ack=0 and rd_data=0 throughout.
2. Count latency and strobes: drive 4 FS02 falls, spaced 10 clks apart.
   - Each FS update lands exactly SYNC+1=3 edges after the sample edge.
   - After the 4th fall, FS=4 (FS05=1, FS03=FS04=0).
   - On that cycle FA=0b100 and FB=0b011.
3. Wrap: with STAGES=4, drive 16 falls. On the 16th update expect FS=0, wrap=1 and FB=0b1111 for exactly one cycle.
4. Hold: drive 3 falls with hold=1. Expect FS unchanged, no strobes, and lost=1. Then perform a read: rd_lost=1, and lost=0 on the following cycle.
5. Coincident capture and increment: with count=7, raise rd_req so its capture edge is the same edge as an increment. Expect rd_data=7, rd_ack=1 and FS=8. Drop rd_req: rd_ack goes to 0 one edge later.
6. Reset mid-handshake: with rd_ack=1 and the count at 5, pulse rst_ low for 1 ns between clk edges. Expect rd_ack, rd_data and FS to go to 0 immediately. A re-request after reset captures 0.
